// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO and its users.
package fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 32;

    typedef logic [DEF_FIFO_WIDTH-1:0] word_t;

endpackage : fifo_pkg

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with one write port and one registered read port.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wrEn,
    input  logic [ADDR_W-1:0]     wrAddr,
    input  logic [FIFO_WIDTH-1:0] wrData,
    input  logic                  rdEn,
    input  logic [ADDR_W-1:0]     rdAddr,
    output logic [FIFO_WIDTH-1:0] rdData
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    // Store the incoming word at the write index.
    // NOTE: the array has no reset; contents are only meaningful once written,
    // and leaving it out keeps the storage a plain register file.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/flag control around a register-array memory.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_W:0]       wrptr,
    output logic [ADDR_W:0]       rdptr
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic wrAccept;
    logic rdAccept;

    // Requests are dropped silently when they would overflow or underflow.
    assign wrAccept = wr_en && !full;
    assign rdAccept = rd_en && !empty;

    // Equal pointers mean empty; equal index with differing wrap bit means full.
    assign empty = (wrptr == rdptr);
    assign full  = (wrptr[ADDR_W] != rdptr[ADDR_W]) &&
                   (wrptr[ADDR_W-1:0] == rdptr[ADDR_W-1:0]);

    // Advance pointers on accepted operations, wrapping modulo 2^(ADDR_W+1).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrptr <= '0;
            rdptr <= '0;
        end else begin
            if (wrAccept) begin
                wrptr <= wrptr + PTR_ONE;
            end
            if (rdAccept) begin
                rdptr <= rdptr + PTR_ONE;
            end
        end
    end

    sync_fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) memInst (
        .clk    (clk),
        .rstN   (rstN),
        .wrEn   (wrAccept),
        .wrAddr (wrptr[ADDR_W-1:0]),
        .wrData (data_in),
        .rdEn   (rdAccept),
        .rdAddr (rdptr[ADDR_W-1:0]),
        .rdData (data_out)
    );

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo with a queue-based reference model.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = DEF_FIFO_DEPTH;

    logic       clk;
    logic       rstN;
    logic       wr_en;
    logic       rd_en;
    word_t      data_in;
    word_t      data_out;
    logic       empty;
    logic       full;
    logic [5:0] wrptr;
    logic [5:0] rdptr;

    sync_fifo dut (
        .clk      (clk),
        .rstN     (rstN),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .wrptr    (wrptr),
        .rdptr    (rdptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;

    // Reference model state
    word_t      sbQueue[$];
    word_t      expData;
    logic [5:0] mWr;
    logic [5:0] mRd;
    bit         lastWrAcc;

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkState(input string tag);
        checkVal({tag, ".data_out"}, 32'(data_out), 32'(expData));
        checkVal({tag, ".empty"},    32'(empty),    32'(sbQueue.size() == 0));
        checkVal({tag, ".full"},     32'(full),     32'(sbQueue.size() == DEPTH));
        checkVal({tag, ".wrptr"},    32'(wrptr),    32'(mWr));
        checkVal({tag, ".rdptr"},    32'(rdptr),    32'(mRd));
    endtask

    task automatic modelReset();
        sbQueue.delete();
        expData = '0;
        mWr     = '0;
        mRd     = '0;
    endtask

    // Drive one cycle, update the model, then check outputs 1 time unit after the edge.
    task automatic step(input string tag, input bit w, input bit r, input word_t d);
        bit wa;
        bit ra;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        wa = w && (sbQueue.size() != DEPTH);
        ra = r && (sbQueue.size() != 0);
        @(posedge clk);
        #1;
        if (ra) begin
            expData = sbQueue.pop_front();
            mRd     = mRd + 6'd1;
        end
        if (wa) begin
            sbQueue.push_back(d);
            mWr = mWr + 6'd1;
        end
        lastWrAcc = wa;
        checkState(tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin : stimulus
        logic [5:0] occ;
        logic [5:0] prevWr;
        logic [5:0] savedPtr;
        bit         wrapped;
        int         wrCount;
        int         iter;

        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        rstN    = 1'b1;
        modelReset();

        // Reset held for 100 time units
        #1 rstN = 1'b0;
        #99;
        checkState("reset");
        #1 rstN = 1'b1;

        // Fill with 0x00..0x1F
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, word_t'(i));
        checkVal("fill.full_flag", 32'(full), 32'd1);
        checkVal("fill.wrptr_end", 32'(wrptr), 32'h20);
        checkVal("fill.rdptr_end", 32'(rdptr), 32'h0);
        step("overflow", 1'b1, 1'b0, 8'hAA);
        checkVal("overflow.wrptr", 32'(wrptr), 32'h20);

        // Drain; expect 0x00..0x1F in order
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            checkVal("drain.order", 32'(data_out), 32'(i));
        end
        checkVal("drain.empty_flag", 32'(empty), 32'd1);
        step("underflow", 1'b0, 1'b1, '0);
        checkVal("underflow.data_out", 32'(data_out), 32'h1F);
        checkVal("underflow.rdptr", 32'(rdptr), 32'h20);

        // Empty + write + read: write only, no bypass
        step("empty_both", 1'b1, 1'b1, 8'h5A);
        checkVal("empty_both.rdptr", 32'(rdptr), 32'h20);
        checkVal("empty_both.empty", 32'(empty), 32'd0);
        checkVal("empty_both.data_out", 32'(data_out), 32'h1F);
        step("empty_both.drain", 1'b0, 1'b1, '0);
        checkVal("empty_both.readback", 32'(data_out), 32'h5A);

        // Concurrent read/write with 5 words held
        for (int i = 0; i < 5; i++) step("conc.pre", 1'b1, 1'b0, word_t'($urandom_range(255)));
        for (int i = 0; i < 10; i++) begin
            step("conc", 1'b1, 1'b1, word_t'($urandom_range(255)));
            occ = wrptr - rdptr;
            checkVal("conc.occupancy", 32'(occ), 32'd5);
        end
        for (int i = 0; i < 5; i++) step("conc.post", 1'b0, 1'b1, '0);

        // Wrap: 48 accepted writes interleaved with random reads
        wrapped = 1'b0;
        wrCount = 0;
        iter    = 0;
        while (wrCount < 48 && iter < 1000) begin
            prevWr = wrptr;
            step("wrap", ($urandom_range(9) < 6), ($urandom_range(9) < 4),
                 word_t'($urandom_range(255)));
            if (lastWrAcc) wrCount++;
            if (wrptr < prevWr) wrapped = 1'b1;
            iter++;
        end
        checkVal("wrap.writes_done", 32'(wrCount), 32'd48);
        checkVal("wrap.ptr_wrapped", 32'(wrapped), 32'd1);
        iter = 0;
        while (sbQueue.size() != 0 && iter < 100) begin
            step("wrap.drain", 1'b0, 1'b1, '0);
            iter++;
        end

        // Full + write + read: read only
        while (sbQueue.size() != DEPTH) step("full.fill", 1'b1, 1'b0, word_t'($urandom_range(255)));
        checkVal("full.flag", 32'(full), 32'd1);
        savedPtr = wrptr;
        step("full_both", 1'b1, 1'b1, 8'hC3);
        checkVal("full_both.wrptr", 32'(wrptr), 32'(savedPtr));
        checkVal("full_both.full", 32'(full), 32'd0);
        while (sbQueue.size() != 0) step("full.drain", 1'b0, 1'b1, '0);

        // Reset mid-stream, off the clock edge
        for (int i = 0; i < 3; i++) step("midrst.pre", 1'b1, 1'b0, word_t'(8'h70 + i));
        step("midrst.rd", 1'b0, 1'b1, '0);
        #3 rstN = 1'b0;
        #1;
        modelReset();
        checkState("midrst");
        #2 rstN = 1'b1;
        step("midrst.wr", 1'b1, 1'b0, 8'h3C);
        step("midrst.rd2", 1'b0, 1'b1, '0);
        checkVal("midrst.new_data", 32'(data_out), 32'h3C);
        checkVal("midrst.empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sync_fifo
